// File: rtl/instr_fetch_decode.sv
// PDP-8 instruction fetch/decode front end: fetches the word at PC_value, resolves one level
// of indirection and hands a one-hot decoded instruction to the execution unit under stall.
module instr_fetch_decode #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o0200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] PC_value,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                  ifu_rd_valid,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH+5:0] pdp_mem_opcode,
  output logic [21:0]           pdp_op7_opcode,
  output logic                  decode_err
);

  // pdp_mem_opcode = {JMP, JMS, DCA, ISZ, TAD, AND, EA}; pdp_op7_opcode bit order follows decode_op7.
  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    FETCH_WAIT = 3'd1,
    IND_WAIT   = 3'd2,
    ISSUE      = 3'd3,
    WAIT_BUSY  = 3'd4,
    HALTED     = 3'd5
  } state_t;

  localparam int OP7_HLT = 12;

  function automatic logic [21:0] decode_op7(input logic [11:0] ir);
    logic [21:0] f;
    f = 22'd0;
    case (ir)
      12'o7000: f[0]  = 1'b1;  // NOP
      12'o7001: f[1]  = 1'b1;  // IAC
      12'o7004: f[2]  = 1'b1;  // RAL
      12'o7006: f[3]  = 1'b1;  // RTL
      12'o7010: f[4]  = 1'b1;  // RAR
      12'o7012: f[5]  = 1'b1;  // RTR
      12'o7020: f[6]  = 1'b1;  // CML
      12'o7040: f[7]  = 1'b1;  // CMA
      12'o7041: f[8]  = 1'b1;  // CIA
      12'o7100: f[9]  = 1'b1;  // CLL
      12'o7200: f[10] = 1'b1;  // CLA1
      12'o7300: f[11] = 1'b1;  // CLA_CLL
      12'o7402: f[12] = 1'b1;  // HLT
      12'o7404: f[13] = 1'b1;  // OSR
      12'o7410: f[14] = 1'b1;  // SKP
      12'o7420: f[15] = 1'b1;  // SNL
      12'o7430: f[16] = 1'b1;  // SZL
      12'o7440: f[17] = 1'b1;  // SZA
      12'o7450: f[18] = 1'b1;  // SNA
      12'o7500: f[19] = 1'b1;  // SMA
      12'o7510: f[20] = 1'b1;  // SPA
      12'o7600: f[21] = 1'b1;  // CLA2
      default:  f     = 22'd0;
    endcase
    return f;
  endfunction

  state_t                r_state;
  logic                  r_rd_req;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH+5:0] r_mem;
  logic [21:0]           r_op7;
  logic                  r_err;
  logic [5:0]            r_pend_flag;

  logic [11:0]           w_ir;
  logic [2:0]            w_opc;
  logic [ADDR_WIDTH-1:0] w_ea;
  logic [5:0]            w_mem_flag;
  logic [21:0]           w_op7;

  assign w_ir       = ifu_rd_data[11:0];
  assign w_opc      = w_ir[11:9];
  // IR[7] selects the current page (upper PC bits) versus page zero.
  assign w_ea       = w_ir[7] ? {PC_value[ADDR_WIDTH-1:7], w_ir[6:0]}
                              : {{(ADDR_WIDTH-7){1'b0}}, w_ir[6:0]};
  assign w_mem_flag = 6'b000001 << w_opc;
  assign w_op7      = decode_op7(w_ir);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= FETCH;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
      r_mem       <= '0;
      r_op7       <= 22'd0;
      r_err       <= 1'b0;
      r_pend_flag <= 6'd0;
    end else begin
      r_rd_req <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        FETCH: begin
          if (!stall) begin
            r_rd_addr <= PC_value;
            r_rd_req  <= 1'b1;
            r_state   <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (ifu_rd_valid) begin
            if (w_opc <= 3'd5) begin
              if (w_ir[8]) begin
                r_rd_addr   <= w_ea;
                r_rd_req    <= 1'b1;
                r_pend_flag <= w_mem_flag;
                r_state     <= IND_WAIT;
              end else begin
                r_mem   <= {w_mem_flag, w_ea};
                r_state <= ISSUE;
              end
            end else if ((w_opc == 3'd7) && (w_op7 != 22'd0)) begin
              r_op7   <= w_op7;
              r_state <= ISSUE;
            end else begin
              // Unsupported words become a NOP so the execution unit still advances the PC.
              r_op7   <= 22'd1;
              r_err   <= 1'b1;
              r_state <= ISSUE;
            end
          end
        end
        IND_WAIT: begin
          if (ifu_rd_valid) begin
            r_mem   <= {r_pend_flag, ifu_rd_data[ADDR_WIDTH-1:0]};
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            r_mem   <= '0;
            r_op7   <= 22'd0;
            r_state <= r_op7[OP7_HLT] ? HALTED : WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (stall) begin
            r_state <= FETCH;
          end
        end
        HALTED: begin
          r_mem <= '0;
          r_op7 <= 22'd0;
        end
        default: begin
          r_state <= FETCH;
          r_mem   <= '0;
          r_op7   <= 22'd0;
        end
      endcase
    end
  end

  assign ifu_rd_req     = r_rd_req;
  assign ifu_rd_addr    = r_rd_addr;
  assign base_addr      = START_ADDRESS;
  assign pdp_mem_opcode = r_mem;
  assign pdp_op7_opcode = r_op7;
  assign decode_err     = r_err;

endmodule
